mem_port_arb: RTL and testbench

MEM_PORT_ARB -- requirements
Module: mem_port_arb

---
 rtl/mem_port_arb.sv | 155 +++++++++++++++
 tb/tb_mem_port_arb.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// Shares one byte-wide RAM/IO port between instruction fetch and load/store.
// Accesses are serialised one byte per cycle; loads see read data one cycle after the address.
module mem_port_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_flush_i,
    output logic        if_done_o,
    output logic [31:0] if_data_o,
    input  logic        mem_req_i,
    input  logic        mem_wr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [1:0]  mem_size_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_done_o,
    output logic [31:0] mem_rdata_o,
    input  logic [7:0]  mem_din_i,
    output logic [7:0]  mem_dout_o,
    output logic [31:0] mem_a_o,
    output logic        mem_wr_o,
    output logic        busy_o
);
    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d, n_q, n_d, nxt, idx;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, acc_q, acc_d;
    logic        if_done_q, if_done_d, mem_done_q, mem_done_d;
    logic [31:0] if_data_q, if_data_d, mem_rdata_q, mem_rdata_d, a_q, a_d;
    logic [7:0]  dout_q, dout_d;
    logic        wr_q, wr_d, busy_q;

    // cnt_q counts cycles spent in the active state; read byte cnt_q-1 arrives now
    assign nxt = cnt_q + 3'd1;
    assign idx = cnt_q - 3'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        acc_d       = acc_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        a_d         = 32'h0;
        dout_d      = dout_q;
        wr_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    state_d = mem_wr_i ? MEM_WR : MEM_RD;
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    n_d     = (mem_size_i == 2'b00) ? 3'd1 : (mem_size_i == 2'b01) ? 3'd2 : 3'd4;
                    cnt_d   = 3'd0;
                    acc_d   = 32'h0;
                    a_d     = mem_addr_i;
                    if (mem_wr_i) begin
                        wr_d   = 1'b1;
                        dout_d = mem_wdata_i[7:0];
                    end
                end else if (if_req_i && !if_flush_i) begin
                    state_d = IF_RD;
                    addr_d  = if_addr_i;
                    n_d     = 3'd4;
                    cnt_d   = 3'd0;
                    acc_d   = 32'h0;
                    a_d     = if_addr_i;
                end
            end
            IF_RD, MEM_RD: begin
                if (state_q == IF_RD && if_flush_i) begin
                    state_d = IDLE;
                end else begin
                    if (cnt_q != 3'd0) acc_d[{idx[1:0], 3'b000} +: 8] = mem_din_i;
                    if (cnt_q == n_q) begin
                        state_d = DONE;
                        if (state_q == IF_RD) begin
                            if_done_d = 1'b1;
                            if_data_d = acc_d;
                        end else begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = acc_d;
                        end
                    end else begin
                        cnt_d = nxt;
                        if (nxt < n_q) a_d = addr_q + {29'b0, nxt};
                    end
                end
            end
            MEM_WR: begin
                if (cnt_q == n_q - 3'd1) begin
                    state_d    = DONE;
                    mem_done_d = 1'b1;
                end else begin
                    cnt_d  = nxt;
                    a_d    = addr_q + {29'b0, nxt};
                    wr_d   = 1'b1;
                    dout_d = wdata_q[{nxt[1:0], 3'b000} +: 8];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            n_q         <= 3'd0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            acc_q       <= 32'h0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= 32'h0;
            mem_rdata_q <= 32'h0;
            a_q         <= 32'h0;
            dout_q      <= 8'h0;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else if (rdy) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            acc_q       <= acc_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            a_q         <= a_d;
            dout_q      <= dout_d;
            wr_q        <= wr_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    // Strobes are masked while frozen so a held done/write shows exactly once after rdy returns
    assign if_done_o   = if_done_q & rdy;
    assign mem_done_o  = mem_done_q & rdy;
    assign mem_wr_o    = wr_q & rdy;
    assign if_data_o   = if_data_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_a_o     = a_q;
    assign mem_dout_o  = dout_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: each loop index c is the cycle number after acceptance.
module tb_mem_port_arb;
    logic        clk = 1'b0, rst, rdy;
    logic        if_req_i, if_flush_i, if_done_o;
    logic [31:0] if_addr_i, if_data_o;
    logic        mem_req_i, mem_wr_i, mem_done_o, mem_wr_o, busy_o;
    logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o, mem_a_o;
    logic [1:0]  mem_size_i;
    logic [7:0]  mem_din_i, mem_dout_o;
    int          n_tests = 0, n_fail = 0;

    logic [7:0] ifb [4] = '{8'h13, 8'h05, 8'h10, 8'h00};
    logic [7:0] wb  [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] b3  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    always #5 clk = ~clk;

    mem_port_arb dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_done_o(if_done_o), .if_data_o(if_data_o),
        .mem_req_i(mem_req_i), .mem_wr_i(mem_wr_i), .mem_addr_i(mem_addr_i),
        .mem_size_i(mem_size_i), .mem_wdata_i(mem_wdata_i),
        .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
        .mem_din_i(mem_din_i), .mem_dout_o(mem_dout_o), .mem_a_o(mem_a_o),
        .mem_wr_o(mem_wr_o), .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ifdone"}, {31'b0, if_done_o}, 32'h0);
        chk({tag, "_memdone"}, {31'b0, mem_done_o}, 32'h0);
        chk({tag, "_ifdata"}, if_data_o, 32'h0);
        chk({tag, "_rdata"}, mem_rdata_o, 32'h0);
        chk({tag, "_dout"}, {24'b0, mem_dout_o}, 32'h0);
        chk({tag, "_a"}, mem_a_o, 32'h0);
        chk({tag, "_wr"}, {31'b0, mem_wr_o}, 32'h0);
        chk({tag, "_busy"}, {31'b0, busy_o}, 32'h0);
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1;
        if_req_i = 0; if_addr_i = 0; if_flush_i = 0;
        mem_req_i = 0; mem_wr_i = 0; mem_addr_i = 0; mem_size_i = 0; mem_wdata_i = 0;
        mem_din_i = 0;
        tick(); tick();
        #1;
        chk_all_zero("reset");
        rst = 1'b1;
        tick();

        // Fetch word from 0x100
        if_req_i = 1; if_addr_i = 32'h100;
        for (int c = 1; c <= 7; c++) begin
            tick();
            mem_din_i = (c >= 2 && c <= 5) ? ifb[c-2] : 8'h00;
            if (c == 6) if_req_i = 0;
            #1;
            chk($sformatf("if_a_c%0d", c), mem_a_o, (c <= 4) ? 32'h100 + c - 1 : 32'h0);
            chk($sformatf("if_done_c%0d", c), {31'b0, if_done_o}, (c == 6) ? 32'h1 : 32'h0);
            chk($sformatf("if_busy_c%0d", c), {31'b0, busy_o}, (c <= 6) ? 32'h1 : 32'h0);
            if (c == 6) chk("if_data", if_data_o, 32'h00100513);
        end

        // Store word 0xDEADBEEF at 0x2000
        mem_req_i = 1; mem_wr_i = 1; mem_size_i = 2'b10; mem_addr_i = 32'h2000; mem_wdata_i = 32'hDEADBEEF;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 5) mem_req_i = 0;
            #1;
            chk($sformatf("sw_wr_c%0d", c), {31'b0, mem_wr_o}, (c <= 4) ? 32'h1 : 32'h0);
            chk($sformatf("sw_a_c%0d", c), mem_a_o, (c <= 4) ? 32'h2000 + c - 1 : 32'h0);
            if (c <= 4) chk($sformatf("sw_dout_c%0d", c), {24'b0, mem_dout_o}, {24'b0, wb[c-1]});
            chk($sformatf("sw_done_c%0d", c), {31'b0, mem_done_o}, (c == 5) ? 32'h1 : 32'h0);
        end

        // Fetch and byte load requested together: load first
        if_req_i = 1; if_addr_i = 32'h0;
        mem_req_i = 1; mem_wr_i = 0; mem_size_i = 2'b00; mem_addr_i = 32'h30000;
        for (int c = 1; c <= 11; c++) begin
            tick();
            mem_din_i = (c == 2) ? 8'h41 : (c >= 6 && c <= 9) ? b3[c-6] : 8'h00;
            if (c == 3) mem_req_i = 0;
            if (c == 10) if_req_i = 0;
            #1;
            chk($sformatf("tie_a_c%0d", c), mem_a_o,
                (c == 1) ? 32'h30000 : (c >= 5 && c <= 8) ? 32'(c - 5) : 32'h0);
            chk($sformatf("tie_mdone_c%0d", c), {31'b0, mem_done_o}, (c == 3) ? 32'h1 : 32'h0);
            chk($sformatf("tie_idone_c%0d", c), {31'b0, if_done_o}, (c == 10) ? 32'h1 : 32'h0);
            chk($sformatf("tie_busy_c%0d", c), {31'b0, busy_o}, (c == 4 || c == 11) ? 32'h0 : 32'h1);
            if (c == 3) chk("tie_rdata", mem_rdata_o, 32'h00000041);
            if (c == 10) begin
                chk("tie_ifdata", if_data_o, 32'h44332211);
                chk("tie_rdata_hold", mem_rdata_o, 32'h00000041);
            end
        end

        // Flush aborts a fetch; refetch accepted straight away, then flushed again
        if_req_i = 1; if_addr_i = 32'h400;
        tick(); #1;
        chk("fl_a1", mem_a_o, 32'h400);
        tick(); if_flush_i = 1; #1;
        chk("fl_a2", mem_a_o, 32'h401);
        tick(); if_flush_i = 0; if_addr_i = 32'h500; #1;
        chk("fl_busy3", {31'b0, busy_o}, 32'h0);
        chk("fl_a3", mem_a_o, 32'h0);
        chk("fl_done3", {31'b0, if_done_o}, 32'h0);
        tick(); if_flush_i = 1; #1;
        chk("fl_busy4", {31'b0, busy_o}, 32'h1);
        chk("fl_a4", mem_a_o, 32'h500);
        tick(); if_flush_i = 0; if_req_i = 0; #1;
        chk("fl_busy5", {31'b0, busy_o}, 32'h0);
        chk("fl_done5", {31'b0, if_done_o}, 32'h0);
        chk("fl_data", if_data_o, 32'h44332211);

        // Half store across a 64K boundary, rdy low in cycles 3..5
        mem_req_i = 1; mem_wr_i = 1; mem_size_i = 2'b01; mem_addr_i = 32'h1FFFF; mem_wdata_i = 32'h0000A55A;
        for (int c = 1; c <= 7; c++) begin
            tick();
            rdy = !(c >= 3 && c <= 5);
            if (c == 6) mem_req_i = 0;
            #1;
            chk($sformatf("sh_wr_c%0d", c), {31'b0, mem_wr_o}, (c <= 2) ? 32'h1 : 32'h0);
            chk($sformatf("sh_a_c%0d", c), mem_a_o,
                (c == 1) ? 32'h1FFFF : (c == 2) ? 32'h20000 : 32'h0);
            if (c <= 2) chk($sformatf("sh_dout_c%0d", c), {24'b0, mem_dout_o}, (c == 1) ? 32'h5A : 32'hA5);
            chk($sformatf("sh_done_c%0d", c), {31'b0, mem_done_o}, (c == 6) ? 32'h1 : 32'h0);
            chk($sformatf("sh_busy_c%0d", c), {31'b0, busy_o}, (c <= 6) ? 32'h1 : 32'h0);
        end

        // Byte store frozen in its only write cycle
        mem_req_i = 1; mem_wr_i = 1; mem_size_i = 2'b00; mem_addr_i = 32'h3000; mem_wdata_i = 32'h00000077;
        for (int c = 1; c <= 4; c++) begin
            tick();
            rdy = (c != 1);
            if (c == 3) mem_req_i = 0;
            #1;
            chk($sformatf("sb_wr_c%0d", c), {31'b0, mem_wr_o}, (c == 2) ? 32'h1 : 32'h0);
            chk($sformatf("sb_a_c%0d", c), mem_a_o, (c <= 2) ? 32'h3000 : 32'h0);
            if (c == 2) chk("sb_dout", {24'b0, mem_dout_o}, 32'h77);
            chk($sformatf("sb_done_c%0d", c), {31'b0, mem_done_o}, (c == 3) ? 32'h1 : 32'h0);
        end

        // Word load reset in cycle 3 with rdy low: reset wins, no done afterwards
        mem_req_i = 1; mem_wr_i = 0; mem_size_i = 2'b10; mem_addr_i = 32'h5000;
        tick(); #1;
        chk("rl_a1", mem_a_o, 32'h5000);
        tick(); mem_din_i = 8'h12; #1;
        tick(); rst = 0; rdy = 0; mem_din_i = 8'h34; #1;
        tick(); rst = 1; rdy = 1; mem_req_i = 0; #1;
        chk_all_zero("rl");
        for (int c = 5; c <= 10; c++) begin
            tick(); #1;
            chk($sformatf("rl_nodone_c%0d", c), {31'b0, mem_done_o}, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
